conv_mac_engine: RTL and testbench

Parametrised, pipelined 2-D convolution engine that consumes im2col window data as a valid/ready stream. It computes LANES K×K dot products per beat, adds a bias, then applies optional ReLU and output saturation. It is the next-generation compute core behind the convolution accelerator: a streamed, back-pressured datapath with runtime window count and signed/unsigned modes, replacing the fixed 26×26 / 3×3 whole-array interface. Kernel and bias are loaded through a small config port before each job.

---
 rtl/conv_mac_engine.sv | 206 ++++++++++++++++++++
 tb/tb_conv_mac_engine.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_engine.sv
// conv_mac_engine: streamed K x K convolution MAC over LANES windows per beat,
// with bias add, optional ReLU and output saturation behind a 3-stage pipeline.
module conv_mac_engine #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned K      = 3,
    parameter int unsigned LANES  = 4,
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            cfg_we,
    input  logic [$clog2(K*K+1)-1:0]        cfg_addr,
    input  logic [DATA_W-1:0]               cfg_data,
    input  logic                            signed_mode,
    input  logic                            relu_en,
    input  logic                            start,
    input  logic [CNT_W-1:0]                num_win,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LANES*K*K*DATA_W-1:0]     in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LANES*OUT_W-1:0]          out_data,
    output logic [LANES-1:0]                out_mask,
    output logic                            out_last,
    output logic                            busy,
    output logic                            done
);
    localparam int unsigned NTAPS  = K * K;
    localparam int unsigned ADDR_W = $clog2(NTAPS + 1);
    localparam int unsigned ACC_W  = 2 * DATA_W + $clog2(NTAPS) + 1;
    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-(2 ** (OUT_W - 1)));
    localparam logic signed [ACC_W-1:0] UMAX = ACC_W'(2 ** OUT_W - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                   state_q;
    logic [CNT_W-1:0]         in_cnt_q, beats_q;
    logic [LANES-1:0]         last_mask_q;
    logic                     signed_q, relu_q;
    logic [DATA_W-1:0]        kernel_q [NTAPS];
    logic [DATA_W-1:0]        bias_q;

    logic                     s1_valid, s1_last, s2_valid, s2_last;
    logic [LANES-1:0]         s1_mask, s2_mask;
    logic signed [ACC_W-1:0]  prod_q [LANES][NTAPS];
    logic signed [ACC_W-1:0]  sum_q [LANES];
    logic signed [ACC_W-1:0]  lane_sum [LANES];

    logic                     advance, fire, last_in;
    logic [CNT_W-1:0]         start_rem, start_beats;
    logic [LANES-1:0]         start_mask;

    function automatic logic signed [ACC_W-1:0] ext(input logic [DATA_W-1:0] v, input logic sgn);
        logic signed [ACC_W-1:0] r;
        r = {{(ACC_W-DATA_W){sgn & v[DATA_W-1]}}, v};
        return r;
    endfunction

    // ReLU first, then clamp into the signed or unsigned output range
    function automatic logic [OUT_W-1:0] post(input logic signed [ACC_W-1:0] s, input logic sgn,
                                              input logic relu);
        logic signed [ACC_W-1:0] v;
        v = s;
        if (relu && sgn && v[ACC_W-1]) v = '0;
        if (sgn) begin
            if (v > SMAX) v = SMAX;
            else if (v < SMIN) v = SMIN;
        end else if (v > UMAX) begin
            v = UMAX;
        end
        return v[OUT_W-1:0];
    endfunction

    assign advance  = !out_valid || out_ready;
    assign in_ready = (state_q == StRun) && advance;
    assign fire     = in_valid && in_ready;
    assign last_in  = (in_cnt_q + CNT_W'(1)) == beats_q;

    // Job geometry derived from num_win at start: beat count and last-beat lane mask
    always_comb begin
        start_rem   = num_win % CNT_W'(LANES);
        start_beats = num_win / CNT_W'(LANES) + CNT_W'(start_rem != '0);
        start_mask  = '1;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (start_rem != '0 && CNT_W'(l) >= start_rem) start_mask[l] = 1'b0;
        end
    end

    // Config port: kernel taps and bias, writable only while idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned t = 0; t < NTAPS; t++) kernel_q[t] <= '0;
            bias_q <= '0;
        end else if (cfg_we && state_q == StIdle) begin
            for (int unsigned t = 0; t < NTAPS; t++) begin
                if (cfg_addr == ADDR_W'(t)) kernel_q[t] <= cfg_data;
            end
            if (cfg_addr == ADDR_W'(NTAPS)) bias_q <= cfg_data;
        end
    end

    // Job control FSM with registered busy/done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            in_cnt_q    <= '0;
            beats_q     <= '0;
            last_mask_q <= '0;
            signed_q    <= 1'b0;
            relu_q      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        beats_q     <= start_beats;
                        last_mask_q <= start_mask;
                        signed_q    <= signed_mode;
                        relu_q      <= relu_en;
                        in_cnt_q    <= '0;
                        busy        <= 1'b1;
                        if (start_beats == '0) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (fire) begin
                        in_cnt_q <= in_cnt_q + CNT_W'(1);
                        if (last_in) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (out_valid && out_ready && out_last) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // S2 combinational: exact adder tree plus extended bias per lane
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_sum[l] = ext(bias_q, signed_q);
            for (int unsigned t = 0; t < NTAPS; t++) lane_sum[l] = lane_sum[l] + prod_q[l][t];
        end
    end

    // S1 products and S2 sums; data-only registers, qualified by the valid chain
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                for (int unsigned t = 0; t < NTAPS; t++) begin
                    prod_q[l][t] <= ext(in_data[(l*NTAPS+t)*DATA_W +: DATA_W], signed_q)
                                  * ext(kernel_q[t], signed_q);
                end
                sum_q[l] <= lane_sum[l];
            end
        end
    end

    // Valid/last/mask chain and S3 output register; whole pipe stalls together
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_mask   <= '0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s2_mask   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_mask  <= '0;
            out_data  <= '0;
        end else if (advance) begin
            s1_valid  <= fire;
            s1_last   <= fire && last_in;
            s1_mask   <= (fire && last_in) ? last_mask_q : '1;
            s2_valid  <= s1_valid;
            s2_last   <= s1_last;
            s2_mask   <= s1_mask;
            out_valid <= s2_valid;
            out_last  <= s2_valid && s2_last;
            out_mask  <= s2_valid ? s2_mask : '0;
            for (int unsigned l = 0; l < LANES; l++) begin
                out_data[l*OUT_W +: OUT_W] <= (s2_valid && s2_mask[l]) ?
                                              post(sum_q[l], signed_q, relu_q) : '0;
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed self-checking bench for conv_mac_engine (default parameters).
module tb_conv_mac_engine;
    localparam int DATA_W = 8;
    localparam int K      = 3;
    localparam int LANES  = 4;
    localparam int OUT_W  = 16;
    localparam int CNT_W  = 16;
    localparam int NTAPS  = K * K;
    localparam int ID     = LANES * NTAPS * DATA_W;
    localparam int OD     = LANES * OUT_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cfg_we;
    logic [3:0]        cfg_addr;
    logic [DATA_W-1:0] cfg_data;
    logic              signed_mode, relu_en, start;
    logic [CNT_W-1:0]  num_win;
    logic              in_valid, in_ready;
    logic [ID-1:0]     in_data;
    logic              out_valid, out_ready;
    logic [OD-1:0]     out_data;
    logic [LANES-1:0]  out_mask;
    logic              out_last, busy, done;

    int vectors = 0;
    int miscompares = 0;

    logic [ID-1:0]    in_q [$];
    logic [OD-1:0]    exp_q [$];
    logic [LANES-1:0] expm_q [$];

    always #5 clk = ~clk;

    conv_mac_engine #(
        .DATA_W(DATA_W), .K(K), .LANES(LANES), .OUT_W(OUT_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .signed_mode(signed_mode), .relu_en(relu_en), .start(start),
        .num_win(num_win), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mask(out_mask), .out_last(out_last), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [ID-1:0] beat(input logic [7:0] c0, c1, c2, c3);
        logic [ID-1:0] b;
        logic [7:0] c;
        b = {(ID/8){8'h5A}};
        for (int l = 0; l < LANES; l++) begin
            c = (l == 0) ? c0 : (l == 1) ? c1 : (l == 2) ? c2 : c3;
            b[(l*NTAPS+4)*DATA_W +: DATA_W] = c;
        end
        return b;
    endfunction

    function automatic logic [OD-1:0] ov(input logic [15:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic set_kernel(input logic [7:0] tap, input logic [7:0] ctr, input logic [7:0] b);
        for (int t = 0; t < NTAPS; t++) cfg_write(4'(t), (t == 4) ? ctr : tap);
        cfg_write(4'd9, b);
    endtask

    task automatic start_job(input int n, input logic sgn, input logic relu);
        signed_mode = sgn; relu_en = relu; num_win = CNT_W'(n); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Streams in_q, checks every output handshake against exp_q/expm_q, then done timing.
    // rdy_mode 1 toggles out_ready 1,0,0,1; inject pulses start and cfg_we mid-job.
    task automatic run_stream(input string tag, input int rdy_mode, input bit inject);
        int sent, got, cyc, acc_cyc, first_out;
        bit stalled;
        logic [OD-1:0] held_d;
        logic [LANES-1:0] held_m;
        logic held_l;
        sent = 0; got = 0; cyc = 0; acc_cyc = -1; first_out = -1; stalled = 0;
        held_d = '0; held_m = '0; held_l = 1'b0;
        in_valid = (in_q.size() > 0);
        if (in_valid) in_data = in_q[0];
        while (got < exp_q.size() && cyc < 200) begin
            out_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (inject && cyc == 1) begin
                start = 1'b1; num_win = 16'd4; cfg_we = 1'b1; cfg_addr = 4'd4; cfg_data = 8'd2;
            end else if (inject && cyc == 2) begin
                start = 1'b0; cfg_we = 1'b0;
            end
            #1;
            if (stalled) begin
                chk({tag, "_hold_data"}, out_data, held_d);
                chk({tag, "_hold_mask"}, 64'(out_mask), 64'(held_m));
                chk({tag, "_hold_last"}, 64'(out_last), 64'(held_l));
            end
            stalled = out_valid && !out_ready;
            if (stalled) begin
                chk({tag, "_stall_in_ready"}, 64'(in_ready), 64'd0);
                held_d = out_data; held_m = out_mask; held_l = out_last;
            end
            if (out_valid && first_out < 0) first_out = cyc;
            if (out_valid && out_ready) begin
                chk({tag, "_data"}, out_data, exp_q[got]);
                chk({tag, "_mask"}, 64'(out_mask), 64'(expm_q[got]));
                chk({tag, "_last"}, 64'(out_last), 64'(got == exp_q.size() - 1));
                got++;
            end
            if (in_valid && in_ready) begin
                if (acc_cyc < 0) acc_cyc = cyc;
                sent++;
            end
            @(posedge clk); #1;
            in_valid = (sent < in_q.size());
            if (in_valid) in_data = in_q[sent];
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_beats_out"}, 64'(got), 64'(exp_q.size()));
        if (rdy_mode == 0) chk({tag, "_latency"}, 64'(first_out - acc_cyc), 64'd3);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy_done"}, 64'(busy), 64'd1);
        @(posedge clk); #1;
        chk({tag, "_done_clr"}, 64'(done), 64'd0);
        chk({tag, "_busy_clr"}, 64'(busy), 64'd0);
        in_q.delete(); exp_q.delete(); expm_q.delete();
    endtask

    initial begin
        reset_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        signed_mode = 1'b0; relu_en = 1'b0; start = 1'b0; num_win = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

        // Reset state
        #3;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_mask", 64'(out_mask), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        #9 reset_n = 1'b1;
        @(posedge clk); #1;

        // Identity kernel, unsigned, 8 windows
        set_kernel(8'h00, 8'h01, 8'h00);
        start_job(8, 1'b0, 1'b0);
        in_q.push_back(beat(8'd1, 8'd2, 8'd3, 8'd4));
        in_q.push_back(beat(8'd200, 8'd17, 8'd99, 8'd255));
        exp_q.push_back(ov(16'd1, 16'd2, 16'd3, 16'd4));
        exp_q.push_back(ov(16'd200, 16'd17, 16'd99, 16'd255));
        expm_q.push_back(4'hF); expm_q.push_back(4'hF);
        run_stream("ident", 0, 1'b0);

        // start / cfg_we during RUN must be ignored
        start_job(8, 1'b0, 1'b0);
        in_q.push_back(beat(8'd11, 8'd22, 8'd33, 8'd44));
        in_q.push_back(beat(8'd55, 8'd66, 8'd77, 8'd88));
        exp_q.push_back(ov(16'd11, 16'd22, 16'd33, 16'd44));
        exp_q.push_back(ov(16'd55, 16'd66, 16'd77, 16'd88));
        expm_q.push_back(4'hF); expm_q.push_back(4'hF);
        run_stream("inject", 0, 1'b1);
        start_job(4, 1'b0, 1'b0);
        in_q.push_back(beat(8'd7, 8'd8, 8'd9, 8'd10));
        exp_q.push_back(ov(16'd7, 16'd8, 16'd9, 16'd10));
        expm_q.push_back(4'hF);
        run_stream("kept_kernel", 0, 1'b0);

        // Unsigned overflow: 9*255*255+255 = 585480 saturates
        set_kernel(8'hFF, 8'hFF, 8'hFF);
        start_job(4, 1'b0, 1'b0);
        in_q.push_back({(ID/8){8'hFF}});
        exp_q.push_back({4{16'hFFFF}});
        expm_q.push_back(4'hF);
        run_stream("usat", 0, 1'b0);

        // Signed: 9*(-128*127)-1 = -146305; ReLU -> 0, else saturate to -32768
        set_kernel(8'h7F, 8'h7F, 8'hFF);
        start_job(4, 1'b1, 1'b1);
        in_q.push_back({(ID/8){8'h80}});
        exp_q.push_back(64'd0);
        expm_q.push_back(4'hF);
        run_stream("relu", 0, 1'b0);
        start_job(4, 1'b1, 1'b0);
        in_q.push_back({(ID/8){8'h80}});
        exp_q.push_back({4{16'h8000}});
        expm_q.push_back(4'hF);
        run_stream("ssat", 0, 1'b0);

        // Partial last beat, signed identity with bias 5
        set_kernel(8'h00, 8'h01, 8'h05);
        start_job(6, 1'b1, 1'b0);
        in_q.push_back(beat(8'hF0, 8'h7F, 8'h00, 8'h80));
        in_q.push_back(beat(8'h01, 8'hFE, 8'h33, 8'h44));
        exp_q.push_back(ov(16'hFFF5, 16'h0084, 16'h0005, 16'hFF85));
        exp_q.push_back(ov(16'h0006, 16'h0003, 16'h0000, 16'h0000));
        expm_q.push_back(4'hF); expm_q.push_back(4'h3);
        run_stream("partial", 0, 1'b0);

        // Backpressure: 5 full beats, out_ready 1,0,0,1
        set_kernel(8'h00, 8'h01, 8'h00);
        start_job(20, 1'b0, 1'b0);
        for (int b = 0; b < 5; b++) begin
            in_q.push_back(beat(8'(b*4+10), 8'(b*4+11), 8'(b*4+12), 8'(b*4+13)));
            exp_q.push_back(ov(16'(b*4+10), 16'(b*4+11), 16'(b*4+12), 16'(b*4+13)));
            expm_q.push_back(4'hF);
        end
        run_stream("bp", 1, 1'b0);

        // num_win 0: done one cycle after start, no output beats
        start_job(0, 1'b0, 1'b0);
        chk("nw0_done", 64'(done), 64'd1);
        chk("nw0_busy", 64'(busy), 64'd1);
        chk("nw0_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("nw0_valid_after", 64'(out_valid), 64'd0);
            chk("nw0_done_after", 64'(done), 64'd0);
        end

        // Reset mid-DRAIN
        start_job(4, 1'b0, 1'b0);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = beat(8'd5, 8'd6, 8'd7, 8'd8);
        #1;
        chk("rd_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rd_pre_valid", 64'(out_valid), 64'd1);
        chk("rd_pre_data", out_data, ov(16'd5, 16'd6, 16'd7, 16'd8));
        #2 reset_n = 1'b0;
        #1;
        chk("rd_valid", 64'(out_valid), 64'd0);
        chk("rd_data", out_data, 64'd0);
        chk("rd_mask", 64'(out_mask), 64'd0);
        chk("rd_last", 64'(out_last), 64'd0);
        chk("rd_busy", 64'(busy), 64'd0);
        chk("rd_done", 64'(done), 64'd0);
        chk("rd_in_ready_rst", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("rd_no_done", 64'(done), 64'd0);
            chk("rd_no_valid", 64'(out_valid), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
